// File: rtl/kf_bram_sdram_responder.sv
// kf_bram_sdram_responder: block-RAM stand-in for the SDRAM controller with emulated command timing
module kf_bram_sdram_responder #(
  parameter int DEPTH_LOG2     = 14,
  parameter int ACT_CYCLES     = 2,
  parameter int READ_LATENCY   = 2,
  parameter int PRE_CYCLES     = 2,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        sdram_clock,
  input  logic        sdram_reset,
  input  logic [24:0] address,
  input  logic [9:0]  access_num,
  input  logic [15:0] data_in,
  input  logic        ldqm,
  input  logic        udqm,
  input  logic        write_request,
  input  logic        read_request,
  input  logic        enable_refresh,
  output logic [15:0] data_out,
  output logic        write_flag,
  output logic        read_flag,
  output logic        idle,
  output logic        refresh_mode
);
  typedef enum logic [2:0] {IDLE, REFRESH, ACTIVATE, WRITE_BURST, READ_LAT, READ_BURST, PRECHARGE} state_t;
  state_t state, state_d;
  logic [15:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] ptr;
  logic [9:0] cnt;
  logic [7:0] tmr, tload;
  logic rd, lm, um, refresh_pending, tdone, last, unused_addr;
  assign unused_addr = ^address[24:DEPTH_LOG2];
  assign tdone = tmr == 8'd0;
  assign last = cnt == 10'd1;
  assign write_flag = state == WRITE_BURST;
  assign read_flag = state == READ_BURST;
  assign idle = state == IDLE;
  assign refresh_mode = state == REFRESH;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:        state_d = refresh_pending ? REFRESH : (write_request | read_request) ? ACTIVATE : IDLE;
      REFRESH:     state_d = tdone ? IDLE : REFRESH;
      ACTIVATE:    state_d = tdone ? (rd ? READ_LAT : WRITE_BURST) : ACTIVATE;
      WRITE_BURST: state_d = last ? PRECHARGE : WRITE_BURST;
      READ_LAT:    state_d = tdone ? READ_BURST : READ_LAT;
      READ_BURST:  state_d = last ? PRECHARGE : READ_BURST;
      PRECHARGE:   state_d = tdone ? IDLE : PRECHARGE;
      default:     state_d = IDLE;
    endcase
  end
  always_comb begin
    tload = state_d == ACTIVATE  ? 8'(ACT_CYCLES - 1) :
            state_d == READ_LAT  ? 8'(READ_LATENCY - 1) :
            state_d == PRECHARGE ? 8'(PRE_CYCLES - 1) :
            state_d == REFRESH   ? 8'(REFRESH_CYCLES - 1) : 8'd0;
  end
  always_ff @(posedge sdram_clock or posedge sdram_reset) begin
    if (sdram_reset) state <= IDLE;
    else state <= state_d;
  end
  // A refresh pulse landing in the cycle REFRESH is entered must survive the clear.
  always_ff @(posedge sdram_clock or posedge sdram_reset) begin
    if (sdram_reset) begin
      refresh_pending <= 1'b0;
      tmr <= 8'd0;
      cnt <= 10'd0;
      ptr <= '0;
      rd <= 1'b0;
      lm <= 1'b0;
      um <= 1'b0;
      data_out <= 16'd0;
    end else begin
      refresh_pending <= enable_refresh | (refresh_pending & ~(state_d == REFRESH && state != REFRESH));
      tmr <= state_d != state ? tload : tmr - 8'(!tdone);
      if (state == IDLE && state_d == ACTIVATE) begin
        ptr <= address[DEPTH_LOG2-1:0];
        cnt <= access_num == 10'd0 ? 10'd1 : access_num;
        rd <= !write_request;
        lm <= ldqm;
        um <= udqm;
      end
      if (state == WRITE_BURST) begin
        ptr <= ptr + 1'b1;
        cnt <= cnt - 1'b1;
      end
      if ((state == READ_LAT && tdone) || (state == READ_BURST && !last)) begin
        data_out <= mem[ptr];
        ptr <= ptr + 1'b1;
      end
      if (state == READ_BURST) cnt <= cnt - 1'b1;
    end
  end
  always_ff @(posedge sdram_clock) begin
    if (state == WRITE_BURST && !sdram_reset) begin
      if (!lm) mem[ptr][7:0] <= data_in[7:0];
      if (!um) mem[ptr][15:8] <= data_in[15:8];
    end
  end
endmodule

// File: doc/kf_bram_sdram_responder.md
# kf_bram_sdram_responder

- Block-RAM-backed responder for the SDRAM access handshake: `address`/`access_num`/`data_in`, `write_request`/`read_request`/`enable_refresh` in; `write_flag`/`read_flag`/`idle`/`refresh_mode`/`data_out` out.
- Drop-in replacement for the SDRAM controller behind the RAM bridge. Used in simulation and on boards without SDRAM.
- Emulates SDRAM command timing so the initiator sees realistic latency:
  - activate delay
  - CAS latency
  - burst
  - precharge
  - refresh occupancy

## Interface
Parameters:
- DEPTH_LOG2, 14 — memory depth in 16-bit words; address bits above this are ignored.
- ACT_CYCLES, 2 — activate-to-burst delay, ≥1.
- READ_LATENCY, 2 — CAS emulation cycles before read data, ≥1.
- PRE_CYCLES, 2 — precharge cycles after a burst, ≥1.
- REFRESH_CYCLES, 4 — refresh occupancy, ≥1.

Ports:
- sdram_clock  in  1  sole clock.
- sdram_reset  in  1  reset; asynchronous, active-high.
- address  in  25  starting word address.
- access_num  in  10  burst length in words; 0 treated as 1.
- data_in  in  16  write data, held stable by the initiator during the burst.
- ldqm  in  1  high = suppress write of byte [7:0].
- udqm  in  1  high = suppress write of byte [15:8].
- write_request  in  1  level; sampled only in IDLE.
- read_request  in  1  level; sampled only in IDLE.
- enable_refresh  in  1  one-cycle refresh pulse, accepted in any state.
- data_out  out  16  read word; valid in every read_flag cycle.
- write_flag  out  1  high during each write-burst beat.
- read_flag  out  1  high during each read-burst beat.
- idle  out  1  high only in IDLE.
- refresh_mode  out  1  high only in REFRESH.

## Operation
- Moore FSM with states IDLE, REFRESH, ACTIVATE, WRITE_BURST, READ_LAT, READ_BURST, PRECHARGE. All flags are decoded from the registered state.
- refresh_pending:
  - Set by enable_refresh in any state.
  - Cleared on entry to REFRESH.
  - A pulse arriving in the cycle of clearing re-sets it.
- IDLE priority:
  1. refresh_pending → REFRESH.
  2. Else write_request → ACTIVATE (write).
  3. Else read_request → ACTIVATE (read).
  - Write beats read when both requests are asserted.
- ACTIVATE entry latches:
  - ptr = address[DEPTH_LOG2-1:0]
  - cnt = (access_num==0 ? 1 : access_num)
  - direction
  - ldqm/udqm
- ACTIVATE lasts ACT_CYCLES, then goes to WRITE_BURST (write) or READ_LAT (read).
- WRITE_BURST:
  - Each cycle writes data_in to mem[ptr] with the latched byte masks.
  - ptr increments modulo 2^DEPTH_LOG2 (wraps 0x3FFF→0x0000 with the default depth).
  - cnt decrements; exits to PRECHARGE after the last beat.
- READ_LAT lasts READ_LATENCY cycles and prefetches mem[ptr] so data is valid on the first beat.
- READ_BURST:
  - N beats; data_out = mem[ptr] for that beat.
  - ptr wraps as in writes.
  - Byte masks do not affect reads.
- PRECHARGE lasts PRE_CYCLES, then returns to IDLE.
- REFRESH lasts REFRESH_CYCLES, then returns to IDLE. Memory is untouched.
- Requests that drop mid-operation do not abort it; the burst and precharge always complete.
- data_out holds the last read word until the next read beat.
- Reset, including mid-operation:
  - state=IDLE, idle=1, write_flag=0, read_flag=0, refresh_mode=0, data_out=0.
  - refresh_pending and counters are cleared.
  - Memory contents are preserved; no partial write occurs after reset asserts.

## Timing
Cycle 0 is IDLE with the request sampled.
- Write, burst N:
  - ACTIVATE: cycles 1..ACT_CYCLES.
  - write_flag: cycles ACT_CYCLES+1 .. ACT_CYCLES+N.
  - PRECHARGE follows.
  - idle=1 at cycle ACT_CYCLES+N+PRE_CYCLES+1. Defaults, N=1: write_flag at cycle 3, idle at cycle 6.
- Read, burst N:
  - read_flag: cycles ACT_CYCLES+READ_LATENCY+1 .. ACT_CYCLES+READ_LATENCY+N.
  - idle=1 at cycle ACT_CYCLES+READ_LATENCY+N+PRE_CYCLES+1. Defaults, N=1: read_flag at cycle 5, idle at cycle 8.
- Refresh from IDLE: refresh_mode high for cycles 1..REFRESH_CYCLES; idle=1 at cycle REFRESH_CYCLES+1.
- The initiator samples data_out at the clock edge that ends a read_flag cycle.
- Each beat's write commits at the edge ending that write_flag cycle.
- Throughput: one beat per cycle; no gaps within a burst.

## Test plan
- Reset, then write_request with address=0x000123, data_in=0x00A5, access_num=1, masks 0:
  - write_flag high in cycle 3 only; idle returns in cycle 6.
  - A following read of 0x123 gives read_flag in cycle 5 with data_out=0x00A5.
- Byte masks: mem[0x10]=0x1234; write data_in=0xABCD with udqm=1, ldqm=0 → read returns 0x12CD.
- Burst with wrap: address=0x3FFE, access_num=4, write data 0x1111 → four write_flag cycles. Words 0x3FFE, 0x3FFF, 0x0000, 0x0001 read back 0x1111; 0x0002 is unchanged.
- Refresh:
  - enable_refresh pulsed during a read burst → after PRECHARGE, IDLE lasts 1 cycle, then refresh_mode is high for 4 cycles with idle=0.
  - A read_request pending meanwhile is served only after the refresh.
- Simultaneous write_request and read_request in IDLE → write served (write_flag asserts, read_flag never asserts).
  - A request dropped in cycle 1 still completes the full sequence.
- sdram_reset asserted during READ_LAT:
  - All outputs go to reset values immediately (idle=1, data_out=0).
  - Memory contents are intact on a subsequent read.
